cb_cfg_loader: RTL and testbench

//  Serial configuration loader that sits directly upstream of the connection-block array.
//  It accepts a bitstream one bit per valid/ready handshake into a shadow register.
//  On a complete, checked frame it commits the shadow atomically to the 10-bit sel words of NUM_CB connection blocks.
//  The connection blocks therefore never see a partially loaded configuration.

---
 rtl/cb_cfg_pkg.sv | 20 ++
 rtl/cb_cfg_shreg.sv | 40 ++++
 rtl/cb_cfg_loader.sv | 148 ++++++++++++++
 tb/tb_cb_cfg_loader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cb_cfg_pkg.sv
// Shared encodings and sizing helpers for the connection-block configuration loader.
package cb_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
    ST_PARITY = 3'd2,
    ST_COMMIT = 3'd3,
    ST_ERROR  = 3'd4
  } cfg_state_t;

  localparam int SEL_W_DEF  = 10;
  localparam int NUM_CB_DEF = 4;

  // Bit counter must be able to hold TOT itself, not just TOT-1.
  function automatic int cnt_width(input int tot);
    return (tot < 1) ? 1 : $clog2(tot + 1);
  endfunction

endpackage

// File: rtl/cb_cfg_shreg.sv
// TOT-bit shadow shift register, MSB-first fill; with CFG_PARITY_EN it also
// keeps a running even-parity bit over everything shifted since the last clear.
module cb_cfg_shreg #(
  parameter int TOT = 40
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           shift_en,
  input  logic           din,
  output logic [TOT-1:0] q
`ifdef CFG_PARITY_EN
  ,
  output logic           par
`endif
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {q[TOT-2:0], din};
    end
  end

`ifdef CFG_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par <= 1'b0;
    end else if (clr) begin
      par <= 1'b0;
    end else if (shift_en) begin
      par <= par ^ din;
    end
  end
`endif

endmodule

// File: rtl/cb_cfg_loader.sv
// Serial config loader: shifts a frame into a shadow register and commits it atomically
// to sel_out. Define CFG_PARITY_EN to add a trailing even-parity bit and the error state.
//
// state     | meaning
// ----------+------------------------------------------------
// ST_IDLE   | waiting for cfg_start, serial input ignored
// ST_SHIFT  | accepting data bits into the shadow register
// ST_PARITY | accepting the frame-check bit (parity build only)
// ST_COMMIT | one cycle, shadow copied to sel_out on exit
// ST_ERROR  | parity mismatch, cfg_err held until next cfg_start
module cb_cfg_loader
  import cb_cfg_pkg::*;
#(
  parameter int SEL_W  = SEL_W_DEF,
  parameter int NUM_CB = NUM_CB_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_start,
  input  logic                    cfg_valid,
  input  logic                    cfg_bit,
  output logic                    cfg_ready,
  output logic                    cfg_busy,
  output logic                    cfg_done,
  output logic                    cfg_err,
  output logic [NUM_CB*SEL_W-1:0] sel_out
);

  localparam int TOT = NUM_CB * SEL_W;
  localparam int CW  = cnt_width(TOT);
  localparam logic [CW-1:0] LAST = CW'(TOT - 1);

  cfg_state_t     state, state_nxt;
  logic [CW-1:0]  count;
  logic [TOT-1:0] shadow;
  logic           start_ok;
  logic           data_acc;

  assign cfg_ready = (state == ST_SHIFT) || (state == ST_PARITY);
  assign cfg_busy  = (state != ST_IDLE);

  // A start landing on the commit cycle is dropped so the commit always completes.
  assign start_ok  = cfg_start && (state != ST_COMMIT);
  assign data_acc  = (state == ST_SHIFT) && cfg_valid && !cfg_start;

`ifdef CFG_PARITY_EN
  logic par;
  logic par_acc;

  assign par_acc = (state == ST_PARITY) && cfg_valid && !cfg_start;

  cb_cfg_shreg #(.TOT(TOT)) u_shreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (start_ok),
    .shift_en (data_acc),
    .din      (cfg_bit),
    .q        (shadow),
    .par      (par)
  );
`else
  cb_cfg_shreg #(.TOT(TOT)) u_shreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (start_ok),
    .shift_en (data_acc),
    .din      (cfg_bit),
    .q        (shadow)
  );
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (cfg_start) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cfg_start) begin
          state_nxt = ST_SHIFT;
        end else if (data_acc && (count == LAST)) begin
`ifdef CFG_PARITY_EN
          state_nxt = ST_PARITY;
`else
          state_nxt = ST_COMMIT;
`endif
        end
      end
`ifdef CFG_PARITY_EN
      ST_PARITY: begin
        if (cfg_start) begin
          state_nxt = ST_SHIFT;
        end else if (par_acc) begin
          state_nxt = (cfg_bit == par) ? ST_COMMIT : ST_ERROR;
        end
      end
      ST_ERROR: begin
        if (cfg_start) state_nxt = ST_SHIFT;
      end
`endif
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (start_ok) begin
      count <= '0;
    end else if (data_acc) begin
      count <= count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_out  <= '0;
      cfg_done <= 1'b0;
    end else begin
      cfg_done <= (state == ST_COMMIT);
      if (state == ST_COMMIT) sel_out <= shadow;
    end
  end

`ifdef CFG_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
    end else if (start_ok) begin
      cfg_err <= 1'b0;
    end else if (par_acc && (cfg_bit != par)) begin
      cfg_err <= 1'b1;
    end
  end
`else
  assign cfg_err = 1'b0;
`endif

endmodule

// File: tb/tb_cb_cfg_loader.sv
// Scoreboard bench for cb_cfg_loader: driver queues expected commits, a negedge
// monitor pops and compares on every cfg_done and checks sel_out never moves otherwise.
module tb_cb_cfg_loader;

  localparam int SEL_W  = 10;
  localparam int NUM_CB = 4;
  localparam int TOT    = SEL_W * NUM_CB;
`ifdef CFG_PARITY_EN
  localparam bit PARITY_BUILT = 1'b1;
`else
  localparam bit PARITY_BUILT = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cfg_start = 1'b0;
  logic           cfg_valid = 1'b0;
  logic           cfg_bit = 1'b0;
  logic           cfg_ready, cfg_busy, cfg_done, cfg_err;
  logic [TOT-1:0] sel_out;

  cb_cfg_loader #(.SEL_W(SEL_W), .NUM_CB(NUM_CB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_ready (cfg_ready),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .sel_out   (sel_out)
  );

  always #5 clk = ~clk;

  int             n_checks = 0;
  int             n_errors = 0;
  int             done_cnt = 0;
  logic [TOT-1:0] exp_q[$];
  logic [TOT-1:0] sel_prev = '0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_val(input string name, input logic [TOT-1:0] act, input logic [TOT-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done must match the oldest queued frame; otherwise sel_out must hold.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cfg_done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: sel_out %h with no frame expected", sel_out);
        end else begin
          check_val("commit_value", sel_out, exp_q.pop_front());
        end
      end else begin
        check_val("sel_hold", sel_out, sel_prev);
      end
    end
    sel_prev = sel_out;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_bit   = 1'($urandom);
    tick();
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
  endtask

  task automatic send_bit(input logic b, input int gap_pct);
    int gaps = 0;
    int guard = 0;
    while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct && gaps < 4) begin
      cfg_valid = 1'b0;
      cfg_bit   = 1'($urandom);
      tick();
      gaps++;
    end
    cfg_valid = 1'b1;
    cfg_bit   = b;
    while (!cfg_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!cfg_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL handshake_timeout: cfg_ready %b expected 1 within 50 cycles", cfg_ready);
    end
    tick();
    cfg_valid = 1'b0;
  endtask

  // Model: the committed word is exactly the frame sent MSB-first; the check bit is ^v.
  task automatic load_frame(input logic [TOT-1:0] v, input int gap_pct, input logic bad_par);
    int   d0;
    logic commit_exp;
    d0 = done_cnt;
    commit_exp = !(bad_par && PARITY_BUILT);
    if (commit_exp) exp_q.push_back(v);
    pulse_start();
    for (int i = TOT - 1; i >= 0; i--) send_bit(v[i], gap_pct);
    if (PARITY_BUILT) send_bit((^v) ^ bad_par, gap_pct);
    check_bit("done_not_early", cfg_done, 1'b0);
    check_bit("err_after_frame", cfg_err, !commit_exp);
    check_bit("busy_after_frame", cfg_busy, 1'b1);
    tick();
    check_bit("done_latency", cfg_done, commit_exp);
    tick();
    check_bit("done_one_cycle", cfg_done, 1'b0);
    check_int("done_count", done_cnt - d0, commit_exp ? 1 : 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TOT-1:0] f2;
    logic [TOT-1:0] rv;
    int             d0;
    f2 = {10'h3FF, 10'h000, 10'h2AA, 10'h155};

    #1;
    check_val("reset_sel", sel_out, '0);
    check_bit("reset_ready", cfg_ready, 1'b0);
    check_bit("reset_busy", cfg_busy, 1'b0);
    check_bit("reset_done", cfg_done, 1'b0);
    check_bit("reset_err", cfg_err, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Contiguous frame, then CB0 field.
    load_frame(f2, 0, 1'b0);
    check_val("cb0_sel", {{(TOT-SEL_W){1'b0}}, sel_out[SEL_W-1:0]}, {{(TOT-SEL_W){1'b0}}, 10'h155});

    // Different word in between so the gapped reload of f2 has something to change.
    rv = {8'($urandom), $urandom};
    load_frame(rv, 0, 1'b0);
    load_frame(f2, 50, 1'b0);

    // Abort after 17 bits; restart carries a valid bit that must be dropped.
    d0 = done_cnt;
    pulse_start();
    for (int i = 0; i < 17; i++) send_bit(1'($urandom), 30);
    check_int("no_done_aborted", done_cnt - d0, 0);
    load_frame({TOT{1'b1}}, 20, 1'b0);

    for (int n = 0; n < 5; n++) begin
      rv = {8'($urandom), $urandom};
      load_frame(rv, (n % 2) * 50, 1'b0);
    end

    // cfg_valid in IDLE without a start does nothing.
    d0 = done_cnt;
    cfg_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cfg_bit = 1'($urandom);
      tick();
      check_bit("idle_ready", cfg_ready, 1'b0);
      check_bit("idle_busy", cfg_busy, 1'b0);
    end
    cfg_valid = 1'b0;
    check_int("idle_no_done", done_cnt - d0, 0);

`ifdef CFG_PARITY_EN
    load_frame({{(TOT-1){1'b0}}, 1'b1}, 0, 1'b0);
    load_frame({{(TOT-1){1'b0}}, 1'b1}, 0, 1'b1);
    rv = {8'($urandom), $urandom};
    load_frame(rv, 30, 1'b1);
    check_bit("err_state_busy", cfg_busy, 1'b1);
    pulse_start();
    check_bit("err_cleared", cfg_err, 1'b0);
    check_bit("restart_ready", cfg_ready, 1'b1);
    load_frame(rv, 0, 1'b0);
`endif

    // Reset in the middle of a load clears everything immediately.
    pulse_start();
    for (int i = 0; i < 10; i++) send_bit(1'($urandom), 0);
    cfg_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midreset_sel", sel_out, '0);
    check_bit("midreset_ready", cfg_ready, 1'b0);
    check_bit("midreset_busy", cfg_busy, 1'b0);
    check_bit("midreset_done", cfg_done, 1'b0);
    check_bit("midreset_err", cfg_err, 1'b0);
    cfg_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_bit("post_reset_busy", cfg_busy, 1'b0);
    check_bit("post_reset_ready", cfg_ready, 1'b0);
    check_val("post_reset_sel", sel_out, '0);
    load_frame(f2, 50, 1'b0);

    tick();
    check_int("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
